// File: rtl/alu_cmd_link_if.sv
// Byte-stream link between the application and the ALU command front end.
// Carries the inbound command stream and the outbound response stream.
interface alu_cmd_link_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/alu_cmd_link.sv
// Assembles 5-byte command frames, drives the ALU from registers and
// returns a 3-byte {status, result} response after a fixed latency.
module alu_cmd_link #(
  parameter int unsigned ALU_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_link_if.slave      link,
  output logic [3:0]         alu_opcode,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  input  logic [15:0]        alu_result,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_RX,
    S_EXEC,
    S_TX
  } state_e;

  localparam logic [3:0] LAT     = 4'(ALU_LATENCY);
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_RST  = 4'b0001;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  frm_q [4];
  logic [7:0]  frm_d [4];
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  st_q, st_d;
  logic [15:0] res_q, res_d;

  logic [3:0]  hdr_op;
  logic        hdr_bad;
  logic        op_ok;

  assign hdr_op = frm_q[0][3:0];

  always_comb begin
    op_ok = 1'b0;
    unique case (hdr_op)
      4'b0000, 4'b0001, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101: op_ok = 1'b1;
      default:          op_ok = 1'b0;
    endcase
  end

  assign hdr_bad = (frm_q[0][7:4] != 4'h0) || !op_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    frm_d   = frm_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    st_d    = st_q;
    res_d   = res_q;
    unique case (state_q)
      S_RX: begin
        if (link.in_valid) begin
          if (cnt_q != 3'd4) begin
            frm_d[cnt_q[1:0]] = link.in_data;
            cnt_d = cnt_q + 3'd1;
          end else begin
            cnt_d = 3'd0;
            unique case (1'b1)
              hdr_bad: begin
                st_d    = {1'b1, 3'b000, hdr_op};
                res_d   = 16'h0000;
                state_d = S_TX;
              end
              (!hdr_bad && hdr_op == OP_NOP): begin
                state_d = S_RX;
              end
              (!hdr_bad && hdr_op == OP_RST): begin
                op_d    = 4'h0;
                a_d     = 16'h0000;
                b_d     = 16'h0000;
                st_d    = 8'h01;
                res_d   = 16'h0000;
                state_d = S_TX;
              end
              default: begin
                op_d    = hdr_op;
                a_d     = {frm_q[1], frm_q[2]};
                b_d     = {frm_q[3], link.in_data};
                lat_d   = 4'h0;
                state_d = S_EXEC;
              end
            endcase
          end
        end
      end
      S_EXEC: begin
        if (lat_q == LAT) begin
          res_d   = alu_result;
          st_d    = {4'b0000, op_q};
          cnt_d   = 3'd0;
          state_d = S_TX;
        end else begin
          lat_d = lat_q + 4'h1;
        end
      end
      S_TX: begin
        if (link.out_ready) begin
          if (cnt_q == 3'd2) begin
            cnt_d   = 3'd0;
            state_d = S_RX;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX;
      cnt_q   <= 3'd0;
      lat_q   <= 4'h0;
      for (int i = 0; i < 4; i++) frm_q[i] <= 8'h00;
      op_q    <= 4'h0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      st_q    <= 8'h00;
      res_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      frm_q   <= frm_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      st_q    <= st_d;
      res_q   <= res_d;
    end
  end

  // Ready is masked by rst_n so nothing is accepted while reset is held.
  assign link.in_ready  = rst_n && (state_q == S_RX);
  assign link.out_valid = (state_q == S_TX);

  always_comb begin
    link.out_data = 8'h00;
    if (state_q == S_TX) begin
      unique case (cnt_q)
        3'd0:    link.out_data = st_q;
        3'd1:    link.out_data = res_q[15:8];
        3'd2:    link.out_data = res_q[7:0];
        default: link.out_data = 8'h00;
      endcase
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign busy       = (state_q != S_RX);

endmodule

// File: tb/tb_alu_cmd_link.sv
// Scoreboard bench for alu_cmd_link: two instances (latency 0 and 3)
// driven by byte frames, responses checked against expected queues.
module tb_alu_cmd_link;

  logic clk;
  logic rst_n;

  alu_cmd_link_if l0();
  alu_cmd_link_if l1();

  logic [3:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1, r0, r1;
  logic        busy0, busy1;

  int checks;
  int errors;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  function automatic logic [15:0] alu_m(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~(a & b);
      4'b1100: return ~(a | b);
      4'b1101: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  assign r0 = alu_m(op0, a0, b0);
  assign r1 = alu_m(op1, a1, b1);

  alu_cmd_link #(.ALU_LATENCY(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (l0),
    .alu_opcode (op0),
    .alu_a      (a0),
    .alu_b      (b0),
    .alu_result (r0),
    .busy       (busy0)
  );

  alu_cmd_link #(.ALU_LATENCY(3)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .link       (l1),
    .alu_opcode (op1),
    .alu_a      (a1),
    .alu_b      (b1),
    .alu_result (r1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && l0.out_valid && l0.out_ready) begin
      if (q0.size() == 0) chk("spurious0", q0.size(), 1);
      else chk("resp0", l0.out_data, q0.pop_front());
    end
    if (rst_n && l1.out_valid && l1.out_ready) begin
      if (q1.size() == 0) chk("spurious1", q1.size(), 1);
      else chk("resp1", l1.out_data, q1.pop_front());
    end
  end

  task automatic send_byte(input int d, input logic [7:0] b);
    bit got;
    got = 1'b0;
    if (d == 0) begin l0.in_data = b; l0.in_valid = 1'b1; end
    else        begin l1.in_data = b; l1.in_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((d == 0 && l0.in_ready) || (d == 1 && l1.in_ready)) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    l0.in_valid = 1'b0;
    l1.in_valid = 1'b0;
    if (!got) chk("in_timeout", 0, 1);
  endtask

  task automatic send_frame(input int d, input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(d, f[i*8 +: 8]);
  endtask

  task automatic push_exp(input int d, input logic [23:0] r);
    for (int i = 2; i >= 0; i--) begin
      if (d == 0) q0.push_back(r[i*8 +: 8]);
      else        q1.push_back(r[i*8 +: 8]);
    end
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("resp_timeout", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    l0.in_data = 8'h00; l0.in_valid = 1'b0; l0.out_ready = 1'b1;
    l1.in_data = 8'h00; l1.in_valid = 1'b0; l1.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", l0.in_ready, 0);
    chk("rst_out_valid", l0.out_valid, 0);
    chk("rst_out_data", l0.out_data, 8'h00);
    chk("rst_busy", busy0, 0);
    chk("rst_alu", {op0, a0, b0}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", l0.in_ready, 1);
    @(posedge clk); #1;

    // ADD, latency 0
    push_exp(0, 24'h041235);
    send_frame(0, 40'h04_1234_0001);
    chk("add_op", op0, 4'h4);
    chk("add_a", a0, 16'h1234);
    chk("add_b", b0, 16'h0001);
    wait_empty();

    // SUB, latency 3: out_valid first high 5 cycles after b4
    push_exp(1, 24'h05FFFE);
    send_frame(1, 40'h05_0005_0007);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (l1.out_valid && first == 0) first = k;
    end
    chk("sub_latency", first, 5);
    wait_empty();

    // invalid opcode then reserved header bits
    push_exp(0, 24'h820000);
    send_frame(0, 40'h02_AAAA_AAAA);
    push_exp(0, 24'h840000);
    send_frame(0, 40'h14_0001_0001);
    wait_empty();
    chk("err_alu_keep", {op0, a0, b0}, {4'h4, 16'h1234, 16'h0001});

    // NOP: no response, then NOT
    send_frame(0, 40'h00_FFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nop_ready", {l0.in_ready, l0.out_valid}, 2'b10);
    end
    @(posedge clk); #1;
    push_exp(0, 24'h0DFF00);
    send_frame(0, 40'h0D_00FF_0000);
    wait_empty();

    // stalled response
    l0.out_ready = 1'b0;
    push_exp(0, 24'h0900FF);
    send_frame(0, 40'h09_000F_00F0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_data", l0.out_data, 8'h09);
      chk("stall_flags", {l0.out_valid, l0.in_ready, busy0}, 3'b101);
    end
    @(posedge clk); #1;
    l0.out_ready = 1'b1;
    wait_empty();
    chk("stall_done_ready", {l0.in_ready, busy0}, 2'b10);

    // reset mid-frame
    send_byte(0, 8'h08);
    send_byte(0, 8'hF0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_alu", {op0, a0, b0}, 0);
    chk("mrst_flags", {l0.in_ready, l0.out_valid, busy0}, 3'b000);
    chk("mrst_data", l0.out_data, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(0, 24'h0800F0);
    send_frame(0, 40'h08_F0F0_0FFF);
    wait_empty();
    repeat (10) @(negedge clk);
    chk("final_idle", {l0.out_valid, l1.out_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_link.md
# alu_cmd_link

Byte-stream command front end for the 16-bit ALU. It assembles 5-byte command frames from the application link into the 36-bit {opcode, A, B} command word, drives the ALU operand/opcode inputs from registers, and waits a fixed ALU latency. It then samples the result and returns a 3-byte response frame (status, result high, result low) on an output byte stream. Both byte streams use valid/ready handshakes. The block sits between the application link and the ALU.

## Interface
- ALU_LATENCY, default 0, range 0..15: cycles after alu_* update before alu_result is sampled.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  command byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data; a byte transfers when in_valid && in_ready.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_a  out  16  registered operand A.
- alu_b  out  16  registered operand B.
- alu_result  in  16  ALU result.
- out_data  out  8  response byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts; a byte transfers when out_valid && out_ready.
- busy  out  1  high whenever the state is not RX.

## Operation
- Command frame is 5 bytes, MSB first: b0 = {4'b0000, opcode}, b1 = A[15:8], b2 = A[7:0], b3 = B[15:8], b4 = B[7:0].
- Valid opcodes: 0000 NOP, 0001 RESET, 0100 ADD, 0101 SUB, 1000 AND, 1001 OR, 1010 XOR, 1011 NAND, 1100 NOR, 1101 NOT.
- State RX:
  - in_ready = 1.
  - Byte counter runs 0..4.
  - Bytes are held in a frame buffer.
  - On acceptance of b4, exactly one of the following applies, based on the frame:
    - b0[7:4] != 0, or opcode not valid: alu_* unchanged; go to TX with status {1, 3'b000, b0[3:0]} and result 0x0000.
    - NOP: alu_* unchanged; no response; stay in RX with counter 0.
    - RESET: load alu_opcode/alu_a/alu_b = 0; go to TX with status 0x01 and result 0x0000. No EXEC.
    - Other valid opcodes: load alu_opcode/alu_a/alu_b from the frame; go to EXEC.
- State EXEC:
  - in_ready = 0.
  - Lasts ALU_LATENCY+1 cycles, counted by a latency counter.
  - On the final EXEC edge, capture alu_result and go to TX with status {0, 3'b000, opcode}.
- State TX:
  - Sends 3 bytes in order: status, result[15:8], result[7:0].
  - Byte counter runs 0..2.
  - After the third transfer, go to RX with counter 0.
- alu_* hold their value until the next load; they stay stable through TX and the following RX.
- Arithmetic is performed by the ALU only; this block does no computation on A or B.

## Timing
- Reset (asynchronous assert, synchronous deassert use of state):
  - state RX; all counters 0.
  - in_ready = 1 from the first cycle after rst_n high; held 0 while rst_n is low.
  - alu_opcode/alu_a/alu_b = 0; out_data = 0x00; out_valid = 0; busy = 0.
- Reset mid-frame or mid-response discards the partial frame or response. No bytes are emitted afterwards for it.
- In-frame timing (b4 accepted at edge N):
  - alu_* take new values after edge N.
  - EXEC occupies cycles N+1..N+1+ALU_LATENCY.
  - The result is captured at edge N+1+ALU_LATENCY.
  - out_valid is high from the following cycle.
- RESET and error frames: out_valid is high in the cycle after edge N.
- Output stream:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- After the third response byte transfers at edge M, in_ready = 1 in cycle M+1.
  - Throughput is one frame every 5 + (ALU_LATENCY+1) + 3 cycles minimum, for ALU ops with no stalls.
- in_data is ignored when in_ready = 0. in_valid is a don't-care outside RX.
- Gaps in in_valid mid-frame are legal; there is no timeout and the partial frame is held.

## Test plan
- ADD frame 04 12 34 00 01, ALU model, ALU_LATENCY = 0 → alu_opcode = 4, alu_a = 0x1234, alu_b = 0x0001; response 04 12 35.
- SUB frame 05 00 05 00 07 with ALU_LATENCY = 3 → out_valid first high exactly 5 cycles after b4 accepted; response 05 FF FE.
- Invalid opcode frame 02 AA AA AA AA, then reserved-bit frame 14 00 01 00 01 → responses 82 00 00 and 84 00 00; alu_* unchanged from the prior command.
- NOP frame 00 FF FF FF FF followed by NOT frame 0D 00 FF 00 00 → no response for the NOP; in_ready stays 1; then response 0D FF 00.
- out_ready held 0 for 6 cycles in TX → out_data stable at the status byte; in_ready = 0; busy = 1. Release → 3 bytes in order; in_ready = 1 the next cycle.
- rst_n pulsed low after 2 bytes of a frame → all outputs at reset values. Then a full frame 08 F0 F0 0F FF → response 08 00 F0, with no stale bytes.
